// File: rtl/conv_idx_pkg.sv
// ============================================================================
// Module      : conv_idx_pkg
// Description : Shared state encoding and output-dimension helper for the
//               convolution window index generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package conv_idx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A zero stride is rejected at elaboration; return 1 so the division stays legal.
  function automatic int out_dim(input int in_dim, input int k, input int s, input int p);
    if (s <= 0) return 1;
    return (in_dim + 2 * p - k) / s + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/idx_wrap_counter.sv
// ============================================================================
// Module      : idx_wrap_counter
// Description : Counter from 0 to MAX that wraps to 0 on increment at MAX.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module idx_wrap_counter #(
  parameter int MAX       = 2,
  parameter int WIDTH_BIT = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 inc,
  output logic [WIDTH_BIT-1:0] count,
  output logic                 at_max
);

  localparam logic [WIDTH_BIT-1:0] c_max = WIDTH_BIT'(MAX);
  localparam logic [WIDTH_BIT-1:0] c_one = WIDTH_BIT'(1);

  logic [WIDTH_BIT-1:0] r_count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= at_max ? '0 : r_count + c_one;
    end
  end

  assign at_max = (r_count == c_max);
  assign count  = r_count;

endmodule

`default_nettype wire

// File: rtl/conv_window_index_gen.sv
// ============================================================================
// Module      : conv_window_index_gen
// Description : Walks every KxK window of a feature map, emitting output,
//               kernel and input coordinates under valid/ready.
//               CONV_IDX_PAD_EN enables zero-padding support and the pad port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_window_index_gen
  import conv_idx_pkg::*;
#(
  parameter int IN_ROWS   = 4,
  parameter int IN_COLS   = 4,
  parameter int K_SIZE    = 3,
  parameter int STRIDE    = 1,
  parameter int PAD       = 0,
  parameter int WIDTH_BIT = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 valid,
  input  logic                 ready,
  output logic [WIDTH_BIT-1:0] out_r,
  output logic [WIDTH_BIT-1:0] out_c,
  output logic [WIDTH_BIT-1:0] k_i,
  output logic [WIDTH_BIT-1:0] k_j,
  output logic [WIDTH_BIT-1:0] in_r,
  output logic [WIDTH_BIT-1:0] in_c,
  output logic                 win_last,
  output logic                 frame_last
`ifdef CONV_IDX_PAD_EN
  ,
  output logic                 pad
`endif
);

`ifdef CONV_IDX_PAD_EN
  localparam int c_pad = PAD;
`else
  localparam int c_pad = 0;
  if (PAD != 0) begin : g_warn_pad
    $warning("conv_window_index_gen: PAD ignored without CONV_IDX_PAD_EN");
  end
`endif

  localparam int c_out_rows = out_dim(IN_ROWS, K_SIZE, STRIDE, c_pad);
  localparam int c_out_cols = out_dim(IN_COLS, K_SIZE, STRIDE, c_pad);

  if (K_SIZE > IN_ROWS + 2 * c_pad || K_SIZE > IN_COLS + 2 * c_pad) begin : g_err_ksize
    $error("conv_window_index_gen: kernel larger than padded input");
  end
  if (STRIDE == 0) begin : g_err_stride
    $error("conv_window_index_gen: STRIDE must be non-zero");
  end
  if (longint'(IN_ROWS + 2 * c_pad - 1) >= (64'd1 << WIDTH_BIT) ||
      longint'(IN_COLS + 2 * c_pad - 1) >= (64'd1 << WIDTH_BIT)) begin : g_err_width
    $error("conv_window_index_gen: padded coordinates exceed WIDTH_BIT");
  end

  state_t r_state, w_state_next;

  logic [WIDTH_BIT-1:0] w_kj, w_ki, w_oc, w_or;
  logic w_kj_max, w_ki_max, w_oc_max, w_or_max;
  logic w_beat, w_clear, w_all_max;

  assign w_beat    = (r_state == RUN) && ready;
  assign w_clear   = (r_state != RUN);
  assign w_all_max = w_kj_max && w_ki_max && w_oc_max && w_or_max;

  // Kernel column is innermost; each carry fires only when the lower counter wraps.
  idx_wrap_counter #(.MAX(K_SIZE - 1), .WIDTH_BIT(WIDTH_BIT)) u_cnt_kj (
    .clock(clock), .reset(reset), .clear(w_clear), .inc(w_beat),
    .count(w_kj), .at_max(w_kj_max)
  );
  idx_wrap_counter #(.MAX(K_SIZE - 1), .WIDTH_BIT(WIDTH_BIT)) u_cnt_ki (
    .clock(clock), .reset(reset), .clear(w_clear), .inc(w_beat && w_kj_max),
    .count(w_ki), .at_max(w_ki_max)
  );
  idx_wrap_counter #(.MAX(c_out_cols - 1), .WIDTH_BIT(WIDTH_BIT)) u_cnt_oc (
    .clock(clock), .reset(reset), .clear(w_clear), .inc(w_beat && w_kj_max && w_ki_max),
    .count(w_oc), .at_max(w_oc_max)
  );
  idx_wrap_counter #(.MAX(c_out_rows - 1), .WIDTH_BIT(WIDTH_BIT)) u_cnt_or (
    .clock(clock), .reset(reset), .clear(w_clear),
    .inc(w_beat && w_kj_max && w_ki_max && w_oc_max),
    .count(w_or), .at_max(w_or_max)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    valid        = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_next = RUN;
      end
      RUN: begin
        valid = 1'b1;
        busy  = 1'b1;
        if (ready && w_all_max) w_state_next = DONE;
      end
      DONE: begin
        done         = 1'b1;
        busy         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign out_r      = w_or;
  assign out_c      = w_oc;
  assign k_i        = w_ki;
  assign k_j        = w_kj;
  assign in_r       = WIDTH_BIT'(int'(w_or) * STRIDE + int'(w_ki));
  assign in_c       = WIDTH_BIT'(int'(w_oc) * STRIDE + int'(w_kj));
  assign win_last   = valid && w_kj_max && w_ki_max;
  assign frame_last = valid && w_all_max;

`ifdef CONV_IDX_PAD_EN
  assign pad = valid && (int'(in_r) < c_pad || int'(in_r) >= IN_ROWS + c_pad ||
                         int'(in_c) < c_pad || int'(in_c) >= IN_COLS + c_pad);
`endif

endmodule

`default_nettype wire

// File: tb/tb_conv_window_index_gen.sv
// ============================================================================
// Module      : tb_conv_window_index_gen
// Description : Self-checking bench for conv_window_index_gen over several
//               geometries against an arithmetic beat model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv_window_index_gen;

  localparam int W = 8;
`ifdef CONV_IDX_PAD_EN
  localparam int N = 5;
`else
  localparam int N = 4;
`endif

  function automatic int cfg_r(input int d);
    case (d) 0: return 4; 1: return 5; 2: return 6; 3: return 3; default: return 3; endcase
  endfunction
  function automatic int cfg_c(input int d);
    case (d) 0: return 4; 1: return 5; 2: return 5; 3: return 6; default: return 3; endcase
  endfunction
  function automatic int cfg_k(input int d);
    case (d) 0: return 3; 1: return 3; 2: return 2; 3: return 1; default: return 3; endcase
  endfunction
  function automatic int cfg_s(input int d);
    case (d) 0: return 1; 1: return 2; 2: return 2; 3: return 1; default: return 1; endcase
  endfunction
  function automatic int cfg_p(input int d);
    return (d == 4) ? 1 : 0;
  endfunction
  function automatic int odim(input int in_dim, input int k, input int s, input int p);
    return (in_dim + 2 * p - k) / s + 1;
  endfunction

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start [N];
  logic ready [N];
  logic busy [N], done [N], valid [N], win_last [N], frame_last [N];
  logic [W-1:0] out_r [N], out_c [N], k_i [N], k_j [N], in_r [N], in_c [N];
`ifdef CONV_IDX_PAD_EN
  logic pad [N];
`endif

  int n_cmp = 0;
  int n_err = 0;
  int n_pad = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < N; g++) begin : g_dut
    conv_window_index_gen #(
      .IN_ROWS(cfg_r(g)), .IN_COLS(cfg_c(g)), .K_SIZE(cfg_k(g)),
      .STRIDE(cfg_s(g)), .PAD(cfg_p(g)), .WIDTH_BIT(W)
    ) u_dut (
      .clock(clock), .reset(reset), .start(start[g]),
      .busy(busy[g]), .done(done[g]), .valid(valid[g]), .ready(ready[g]),
      .out_r(out_r[g]), .out_c(out_c[g]), .k_i(k_i[g]), .k_j(k_j[g]),
      .in_r(in_r[g]), .in_c(in_c[g]),
      .win_last(win_last[g]), .frame_last(frame_last[g])
`ifdef CONV_IDX_PAD_EN
      , .pad(pad[g])
`endif
    );
  end

  task automatic chk(input string tag, input int d, input int k,
                     input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s dut=%0d beat=%0d observed=%0h expected=%0h", tag, d, k, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input int d, input string tag);
    logic [31:0] all;
    all = {16'd0, out_r[d] | out_c[d] | k_i[d] | k_j[d] | in_r[d] | in_c[d],
           3'd0, valid[d], busy[d], done[d], win_last[d], frame_last[d]};
    chk(tag, d, -1, all, 32'd0);
  endtask

  // Expected beat k: kernel column innermost, output row outermost.
  task automatic chk_beat(input int d, input int k, output bit is_pad);
    int kk, ss, pp, oc_n, total, kj, ki, oc, orr, er, ec;
    kk = cfg_k(d); ss = cfg_s(d); pp = cfg_p(d);
    oc_n  = odim(cfg_c(d), kk, ss, pp);
    total = odim(cfg_r(d), kk, ss, pp) * oc_n * kk * kk;
    kj  = k % kk;
    ki  = (k / kk) % kk;
    oc  = (k / (kk * kk)) % oc_n;
    orr = k / (kk * kk * oc_n);
    er  = orr * ss + ki;
    ec  = oc * ss + kj;
    is_pad = (er < pp) || (er >= cfg_r(d) + pp) || (ec < pp) || (ec >= cfg_c(d) + pp);
    chk("out_r", d, k, 32'(out_r[d]), 32'(orr));
    chk("out_c", d, k, 32'(out_c[d]), 32'(oc));
    chk("k_i", d, k, 32'(k_i[d]), 32'(ki));
    chk("k_j", d, k, 32'(k_j[d]), 32'(kj));
    chk("in_r", d, k, 32'(in_r[d]), 32'(er));
    chk("in_c", d, k, 32'(in_c[d]), 32'(ec));
    chk("win_last", d, k, 32'(win_last[d]), 32'(ki == kk - 1 && kj == kk - 1));
    chk("frame_last", d, k, 32'(frame_last[d]), 32'(k == total - 1));
    chk("busy_run", d, k, 32'(busy[d]), 32'd1);
`ifdef CONV_IDX_PAD_EN
    chk("pad", d, k, 32'(pad[d]), 32'(is_pad));
`endif
  endtask

  // rmode: 0 ready high, 1 three-cycle stall at beat 5, 2 random ready.
  task automatic run_frame(input int d, input int rmode, input int abort_at, input bit poke);
    int kk, total, k, stall;
    bit finished, p;
    kk = cfg_k(d);
    total = odim(cfg_r(d), kk, cfg_s(d), cfg_p(d)) * odim(cfg_c(d), kk, cfg_s(d), cfg_p(d)) * kk * kk;
    k = 0; stall = 0; finished = 0; n_pad = 0;
    @(negedge clock); start[d] = 1'b1;
    @(negedge clock); start[d] = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (rmode == 0) ready[d] = 1'b1;
      else if (rmode == 1) begin
        if (k == 5 && stall < 3) begin ready[d] = 1'b0; stall++; end
        else ready[d] = 1'b1;
      end else ready[d] = ($urandom_range(0, 3) != 0);
      if (valid[d]) begin
        if (k == abort_at) begin
          ready[d] = 1'b0;
          reset = 1'b1;
          @(negedge clock);
          reset = 1'b0;
          chk_idle_zero(d, "reset_mid_frame");
          finished = 1;
          break;
        end
        chk_beat(d, k, p);
        start[d] = poke && (k == 10);
        if (ready[d]) begin
          if (p) n_pad++;
          k++;
        end
      end else begin
        chk("done", d, k, 32'(done[d]), 32'd1);
        chk("busy_done", d, k, 32'(busy[d]), 32'd1);
        chk("beat_count", d, k, 32'(k), 32'(total));
        if (rmode == 0) chk("throughput", d, k, 32'(cyc), 32'(total));
        start[d] = poke;
        finished = 1;
        @(negedge clock);
        break;
      end
      @(negedge clock);
    end
    start[d] = 1'b0;
    ready[d] = 1'b0;
    if (!finished) chk("timeout", d, k, 32'd0, 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk_idle_zero(d, "idle_after_frame");
      @(negedge clock);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      start[i] = 1'b0;
      ready[i] = 1'b0;
    end
    repeat (3) @(negedge clock);
    for (int i = 0; i < N; i++) chk_idle_zero(i, "reset_state");
    reset = 1'b0;

    run_frame(0, 0, -1, 1'b0);
    run_frame(1, 0, -1, 1'b0);
    run_frame(0, 1, -1, 1'b0);
    run_frame(0, 0, -1, 1'b1);
    run_frame(0, 0, 20, 1'b0);
    run_frame(0, 0, -1, 1'b0);
    for (int d = 0; d < N; d++) begin
      run_frame(d, 2, -1, 1'b0);
      run_frame(d, 2, -1, 1'b0);
    end
`ifdef CONV_IDX_PAD_EN
    run_frame(4, 0, -1, 1'b0);
    chk("padded_beats", 4, -1, 32'(n_pad), 32'd32);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/conv_window_index_gen.md
Name: conv_window_index_gen

Overview:
- Parametrised successor to the square free-running (i, j) matrix indexer.
- Walks every convolution window over an IN_ROWS x IN_COLS feature map for a K_SIZE kernel at a given STRIDE.
- Emits output-position, kernel-position and input-pixel coordinates one beat at a time under a valid/ready handshake, with start/done framing.
- Drives address generation for the line buffer / MAC array feeding the conv layer.

Parameters:
- IN_ROWS, 4, input feature-map rows
- IN_COLS, 4, input feature-map columns
- K_SIZE, 3, square kernel side
- STRIDE, 1, window step in both dimensions
- PAD, 0, zero-padding border width; only honoured with CONV_IDX_PAD_EN
- WIDTH_BIT, 8, width of every coordinate output

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; launches a frame when idle
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the final beat is accepted
- valid  out  1  coordinate beat available
- ready  in  1  consumer accepts the beat
- out_r  out  WIDTH_BIT  output-map row
- out_c  out  WIDTH_BIT  output-map column
- k_i  out  WIDTH_BIT  kernel row
- k_j  out  WIDTH_BIT  kernel column
- in_r  out  WIDTH_BIT  out_r*STRIDE + k_i (padded-image coordinates)
- in_c  out  WIDTH_BIT  out_c*STRIDE + k_j
- win_last  out  1  beat is k_i = k_j = K_SIZE-1
- frame_last  out  1  win_last and final output position
- pad  out  1  in_r/in_c lies in the padding border (CONV_IDX_PAD_EN only)

Behaviour:
- Derived dimensions: OUT_ROWS = (IN_ROWS + 2*PAD - K_SIZE)/STRIDE + 1; OUT_COLS likewise from IN_COLS.
- Elaboration $error if K_SIZE > IN_ROWS+2*PAD, K_SIZE > IN_COLS+2*PAD, STRIDE = 0, or IN+2*PAD-1 does not fit in WIDTH_BIT.
- States: IDLE, RUN, DONE.
- IDLE: valid = 0, busy = 0. On start = 1, go to RUN next cycle with all counters at 0.
- RUN: valid = 1, busy = 1. Coordinates hold while valid & !ready.
- Beat order on each valid & ready, next cycle:
  - k_j increments; wraps at K_SIZE-1, carrying into k_i.
  - k_i wraps, carrying into out_c.
  - out_c wraps at OUT_COLS-1, carrying into out_r.
  - Kernel is innermost; out_r is outermost.
- Handshake of the frame_last beat: next state DONE, all counters cleared.
- DONE: lasts exactly one cycle; done = 1, valid = 0, busy = 1. Then IDLE.
- in_r/in_c are combinational from registered counters; zero added latency from counters to coordinates.
- win_last and frame_last are combinational and valid only while valid = 1.
- start in RUN or DONE is ignored, with no queuing. start coincident with reset: reset wins.
- reset at any point: next cycle IDLE, all counters 0, valid = busy = done = 0.
- A frame contains OUT_ROWS*OUT_COLS*K_SIZE^2 beats.
- Throughput: one beat per cycle under constant ready.
- Reset values: every output is 0.

Optional Feature:
- Macro: CONV_IDX_PAD_EN
- Defined:
  - PAD parameter is used in the OUT_ROWS/OUT_COLS formula.
  - pad port exists.
  - pad = 1 when in_r < PAD, in_r >= IN_ROWS+PAD, in_c < PAD, or in_c >= IN_COLS+PAD.
  - Consumer substitutes zero for padded beats; the beat is still emitted and handshaken.
- Undefined:
  - PAD is forced to 0 in all arithmetic.
  - pad port is absent.
  - Elaboration $warning if PAD != 0.

Decomposition:
- Package conv_idx_pkg:
  - state enum (IDLE, RUN, DONE)
  - function out_dim(in, k, s, p)
- Sub-module idx_wrap_counter (parameters MAX, WIDTH_BIT):
  - inputs: clock, reset, clear, inc
  - outputs: count, at_max (wrap flag)
  - Instantiated four times and chained via at_max & inc.

Test Plan:
- IN 4x4, K3, S1, ready = 1, start pulse:
  - 36 beats.
  - Beat 0: all coordinates 0.
  - Beat 8: win_last = 1.
  - Beat 9: out_c = 1, in_c = 1.
  - Beat 35: in = (3,3), frame_last = 1.
  - done one cycle later, then busy = 0.
- IN 5x5, K3, S2:
  - OUT 2x2, 36 beats.
  - Beat 9: out_c = 1, in_c = 2.
  - Beat 35: in = (4,4).
- Backpressure: drop ready for 3 cycles at beat 5 -> coordinates and valid stable, no skipped or duplicated beat, total still 36.
- Control corners:
  - start pulsed mid-RUN and during DONE -> ignored, exactly one done.
  - reset at beat 20 -> IDLE next cycle, outputs 0.
  - A fresh start then yields beat 0 again.
- CONV_IDX_PAD_EN, IN 3x3, K3, PAD1, S1:
  - OUT 3x3, 81 beats.
  - Beat 0: pad = 1.
  - Exactly 32 padded and 49 unpadded beats.
- Random ready with scoreboard model over IN {3..6}, K {1..3}, S {1..2} -> beat sequence matches model exactly.
